// File: rtl/hr_node_mc_pkg.sv
// Shared flit field layout and helpers for the multi-channel hierarchical-ring node.
// Flit: bit 0 valid, bits [ADDR_W:1] dest, remaining bits opaque payload.
package hr_node_mc_pkg;

  localparam int VALID_BIT = 0;
  localparam int DEST_LSB  = 1;
  localparam int DEFL_W    = 16;

  function automatic int dest_msb(input int addr_w);
    return DEST_LSB + addr_w - 1;
  endfunction

  // Saturating add used for the shared deflection counter.
  function automatic logic [DEFL_W-1:0] sat_add(input logic [DEFL_W-1:0] a,
                                                input logic [DEFL_W-1:0] b);
    logic [DEFL_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DEFL_W] ? {DEFL_W{1'b1}} : s[DEFL_W-1:0];
  endfunction

endpackage

// File: rtl/hr_eject_fifo.sv
// Small per-channel eject FIFO. cnt_ok reports whether a push can be taken this
// cycle, counting a same-cycle pop as freeing a slot.
module hr_eject_fifo #(
  parameter int FLIT_W = 144,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [FLIT_W-1:0] din,
  input  logic              pop,
  output logic [FLIT_W-1:0] dout,
  output logic              vld,
  output logic              cnt_ok
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [FLIT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              do_pop;

  assign do_pop = pop && (cnt_q != '0);
  assign vld    = (cnt_q != '0);
  assign dout   = mem_q[rd_ptr_q];
  assign cnt_ok = (cnt_q < CNT_W'(DEPTH)) || do_pop;

  // DEPTH is a power of two, so pointer wrap is the natural binary overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push)   wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/hr_node_mc.sv
// N_CH-channel hierarchical-ring node: registered ring stage, eject with
// deflection on full FIFO, slot-based injection, starvation detect, deflection count.
module hr_node_mc
  import hr_node_mc_pkg::*;
#(
  parameter int                ADDR_W    = 4,
  parameter logic [ADDR_W-1:0] ADDR      = 4'b0010,
  parameter int                N_CH      = 2,
  parameter int                FLIT_W    = 144,
  parameter int                EJ_DEPTH  = 2,
  parameter int                STARVE_TH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH*FLIT_W-1:0]   port_i,
  output logic [N_CH*FLIT_W-1:0]   port_o,
  input  logic [N_CH*FLIT_W-1:0]   port_local_i,
  output logic [N_CH-1:0]          portl_ack,
  output logic [N_CH*FLIT_W-1:0]   port_local_o,
  output logic [N_CH-1:0]          portl_o_vld,
  input  logic [N_CH-1:0]          portl_o_rdy,
  output logic [N_CH-1:0]          starve_o,
  output logic [DEFL_W-1:0]        defl_cnt
);

  localparam int DEST_MSB = dest_msb(ADDR_W);
  localparam int SV_W     = $clog2(STARVE_TH + 1);

  logic [N_CH-1:0]   defl;
  logic [DEFL_W-1:0] defl_sum;
  logic [DEFL_W-1:0] defl_cnt_q, defl_cnt_d;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [FLIT_W-1:0] in_f, loc_f, head, out_d, out_q;
    logic              hit, ej_ok, push, pop, vld, slot_empty, ack, defl_c;
    logic [SV_W-1:0]   stv_cnt_d, stv_cnt_q;
    logic              starve_d, starve_q;

    assign in_f  = port_i[c*FLIT_W +: FLIT_W];
    assign loc_f = port_local_i[c*FLIT_W +: FLIT_W];
    assign pop   = vld && portl_o_rdy[c];

    hr_eject_fifo #(.FLIT_W(FLIT_W), .DEPTH(EJ_DEPTH)) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .push   (push),
      .din    (in_f),
      .pop    (pop),
      .dout   (head),
      .vld    (vld),
      .cnt_ok (ej_ok)
    );

    // The slot is free when nothing arrives or the arriving flit was ejected.
    always_comb begin
      hit        = in_f[VALID_BIT] && (in_f[DEST_MSB:DEST_LSB] == ADDR);
      push       = hit && ej_ok;
      defl_c     = hit && !ej_ok;
      slot_empty = !in_f[VALID_BIT] || push;
      ack        = slot_empty && loc_f[VALID_BIT] && !rst;
      out_d      = '0;
      if (ack)             out_d = loc_f;
      else if (!slot_empty) out_d = in_f;
      stv_cnt_d = '0;
      if (loc_f[VALID_BIT] && !ack)
        stv_cnt_d = (stv_cnt_q == SV_W'(STARVE_TH)) ? stv_cnt_q : stv_cnt_q + 1'b1;
      starve_d = (stv_cnt_d == SV_W'(STARVE_TH));
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        out_q     <= '0;
        stv_cnt_q <= '0;
        starve_q  <= 1'b0;
      end else begin
        out_q     <= out_d;
        stv_cnt_q <= stv_cnt_d;
        starve_q  <= starve_d;
      end
    end

    assign defl[c]                            = defl_c;
    assign portl_ack[c]                       = ack;
    assign port_o[c*FLIT_W +: FLIT_W]         = out_q;
    assign port_local_o[c*FLIT_W +: FLIT_W]   = head;
    assign portl_o_vld[c]                     = vld;
    assign starve_o[c]                        = starve_q;
  end

  always_comb begin
    defl_sum = '0;
    for (int i = 0; i < N_CH; i++) defl_sum = defl_sum + DEFL_W'(defl[i]);
    defl_cnt_d = sat_add(defl_cnt_q, defl_sum);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) defl_cnt_q <= '0;
    else     defl_cnt_q <= defl_cnt_d;
  end

  assign defl_cnt = defl_cnt_q;

endmodule

// File: tb/tb_hr_node_mc.sv
// Scoreboard bench for hr_node_mc: directed scenarios plus random traffic, checked
// against a queue-based reference model of the node's ring/eject/inject rules.
module tb_hr_node_mc;

  localparam int                ADDR_W    = 4;
  localparam logic [ADDR_W-1:0] ADDR      = 4'b0010;
  localparam int                N_CH      = 2;
  localparam int                FLIT_W    = 144;
  localparam int                EJ_DEPTH  = 2;
  localparam int                STARVE_TH = 8;
  localparam int                NW        = N_CH * FLIT_W;

  logic            clk;
  logic            rst;
  logic [NW-1:0]   port_i, port_o, port_local_i, port_local_o;
  logic [N_CH-1:0] portl_ack, portl_o_vld, portl_o_rdy, starve_o;
  logic [15:0]     defl_cnt;

  hr_node_mc #(
    .ADDR_W(ADDR_W), .ADDR(ADDR), .N_CH(N_CH), .FLIT_W(FLIT_W),
    .EJ_DEPTH(EJ_DEPTH), .STARVE_TH(STARVE_TH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .port_i       (port_i),
    .port_o       (port_o),
    .port_local_i (port_local_i),
    .portl_ack    (portl_ack),
    .port_local_o (port_local_o),
    .portl_o_vld  (portl_o_vld),
    .portl_o_rdy  (portl_o_rdy),
    .starve_o     (starve_o),
    .defl_cnt     (defl_cnt)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // scoreboard state
  logic [NW-1:0]     out_q[$];
  logic [N_CH-1:0]   ack_q[$];
  logic [N_CH-1:0]   vld_q[$];
  logic [N_CH-1:0]   stv_q[$];
  logic [15:0]       defl_q[$];
  logic [FLIT_W-1:0] m_fifo[N_CH][$];
  logic [FLIT_W-1:0] ej_q[N_CH][$];
  int                wait_c[N_CH];
  longint            defl_total;
  logic [N_CH-1:0]   last_ack;
  logic [FLIT_W-1:0] cur_loc[N_CH];
  bit                mon_en;
  int                checks;
  int                errors;

  task automatic chk(input string nm, input logic [NW-1:0] got, input logic [NW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  function automatic logic [FLIT_W-1:0] mk(input logic [ADDR_W-1:0] dest, input bit valid);
    logic [FLIT_W-1:0] f;
    f = '0;
    f[0] = valid;
    f[ADDR_W:1] = dest;
    return f;
  endfunction

  function automatic logic [FLIT_W-1:0] rnd_flit(input int pct_valid);
    logic [FLIT_W-1:0] f;
    for (int i = 0; i < FLIT_W; i += 16) f[i +: 16] = 16'($urandom());
    f[0] = ($urandom_range(0, 99) < pct_valid);
    f[ADDR_W:1] = ($urandom_range(0, 1) == 1) ? ADDR : ADDR_W'($urandom_range(0, 15));
    return f;
  endfunction

  function automatic logic [NW-1:0] put(input logic [NW-1:0] v, input int c,
                                        input logic [FLIT_W-1:0] f);
    v[c*FLIT_W +: FLIT_W] = f;
    return v;
  endfunction

  function automatic void model_clear();
    out_q.delete(); ack_q.delete(); vld_q.delete(); stv_q.delete(); defl_q.delete();
    for (int c = 0; c < N_CH; c++) begin
      m_fifo[c].delete();
      ej_q[c].delete();
      wait_c[c] = 0;
    end
    defl_total = 0;
    last_ack = '0;
  endfunction

  // driver: one cycle of stimulus, with the model's expectations pushed to the queues
  task automatic drive_cycle(input logic [NW-1:0] pin, input logic [NW-1:0] lin,
                             input logic [N_CH-1:0] rdy);
    logic [NW-1:0]     nxt;
    logic [N_CH-1:0]   ack, vld, stv;
    logic [FLIT_W-1:0] f, l;
    bit                hit, empty;
    int                nd;
    @(negedge clk);
    port_i = pin;
    port_local_i = lin;
    portl_o_rdy = rdy;
    nxt = '0;
    nd = 0;
    for (int c = 0; c < N_CH; c++) begin
      f = pin[c*FLIT_W +: FLIT_W];
      l = lin[c*FLIT_W +: FLIT_W];
      vld[c] = (m_fifo[c].size() != 0);
      if (vld[c] && rdy[c]) ej_q[c].push_back(m_fifo[c].pop_front());
      hit = f[0] && (f[ADDR_W:1] == ADDR);
      empty = !f[0];
      if (hit && m_fifo[c].size() < EJ_DEPTH) begin
        m_fifo[c].push_back(f);
        empty = 1;
      end else if (hit) begin
        nd++;
      end
      ack[c] = empty && l[0];
      if (ack[c])      nxt[c*FLIT_W +: FLIT_W] = l;
      else if (!empty) nxt[c*FLIT_W +: FLIT_W] = f;
      if (l[0] && !ack[c]) wait_c[c] = (wait_c[c] >= STARVE_TH) ? STARVE_TH : wait_c[c] + 1;
      else                 wait_c[c] = 0;
      stv[c] = (wait_c[c] == STARVE_TH);
    end
    defl_total += nd;
    ack_q.push_back(ack);
    vld_q.push_back(vld);
    out_q.push_back(nxt);
    stv_q.push_back(stv);
    defl_q.push_back((defl_total > 65535) ? 16'hFFFF : 16'(defl_total));
    last_ack = ack;
  endtask

  task automatic idle_cycles(input int n, input logic [N_CH-1:0] rdy);
    for (int i = 0; i < n; i++) drive_cycle('0, '0, rdy);
  endtask

  task automatic random_cycles(input int n);
    logic [NW-1:0] pin, lin;
    for (int i = 0; i < n; i++) begin
      pin = '0;
      lin = '0;
      for (int c = 0; c < N_CH; c++) begin
        if (last_ack[c] || !cur_loc[c][0]) cur_loc[c] = rnd_flit(50);
        pin = put(pin, c, rnd_flit(60));
        lin = put(lin, c, cur_loc[c]);
      end
      drive_cycle(pin, lin, N_CH'($urandom_range(0, (1 << N_CH) - 1)));
    end
  endtask

  // monitor: combinational outputs, sampled mid-low-phase
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (mon_en && ack_q.size() > 0) begin
        chk("portl_ack", NW'(portl_ack), NW'(ack_q.pop_front()));
        chk("portl_o_vld", NW'(portl_o_vld), NW'(vld_q.pop_front()));
        for (int c = 0; c < N_CH; c++) begin
          if (portl_o_vld[c] && portl_o_rdy[c]) begin
            if (ej_q[c].size() == 0) begin
              checks++;
              errors++;
              $display("FAIL eject_head ch%0d got %h exp none", c,
                       port_local_o[c*FLIT_W +: FLIT_W]);
            end else begin
              chk($sformatf("eject_head_ch%0d", c), NW'(port_local_o[c*FLIT_W +: FLIT_W]),
                  NW'(ej_q[c].pop_front()));
            end
          end
        end
      end
    end
  end

  // monitor: registered outputs, sampled just after the edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mon_en && out_q.size() > 0) begin
        chk("port_o", port_o, out_q.pop_front());
        chk("starve_o", NW'(starve_o), NW'(stv_q.pop_front()));
        chk("defl_cnt", NW'(defl_cnt), NW'(defl_q.pop_front()));
      end
    end
  end

  task automatic reset_mid_traffic();
    logic [NW-1:0] lin;
    lin = '0;
    for (int c = 0; c < N_CH; c++) lin = put(lin, c, mk(4'h3, 1'b1));
    @(negedge clk);
    port_i = '0;
    port_local_i = lin;
    portl_o_rdy = '0;
    #4;
    mon_en = 0;
    rst = 1'b1;
    #1;
    chk("rst_port_o", port_o, '0);
    chk("rst_vld", NW'(portl_o_vld), '0);
    chk("rst_defl", NW'(defl_cnt), '0);
    chk("rst_starve", NW'(starve_o), '0);
    chk("rst_ack", NW'(portl_ack), '0);
    model_clear();
    @(posedge clk);
    #1;
    chk("rst_hold_port_o", port_o, '0);
    @(negedge clk);
    port_i = '0;
    port_local_i = '0;
    rst = 1'b0;
    mon_en = 1;
  endtask

  initial begin
    logic [NW-1:0] pin, lin;
    checks = 0;
    errors = 0;
    mon_en = 0;
    for (int c = 0; c < N_CH; c++) cur_loc[c] = '0;
    model_clear();
    rst = 1'b1;
    port_i = '0;
    portl_o_rdy = '0;
    port_local_i = '0;
    for (int c = 0; c < N_CH; c++) port_local_i = put(port_local_i, c, mk(4'h1, 1'b1));
    #3;
    chk("init_port_o", port_o, '0);
    chk("init_vld", NW'(portl_o_vld), '0);
    chk("init_starve", NW'(starve_o), '0);
    chk("init_defl", NW'(defl_cnt), '0);
    chk("init_ack", NW'(portl_ack), '0);
    @(negedge clk);
    @(negedge clk);
    port_local_i = '0;
    rst = 1'b0;
    mon_en = 1;

    // pass-through on ch0 (dest 1)
    drive_cycle(put('0, 0, mk(4'h1, 1'b1)), '0, '0);
    idle_cycles(1, '0);

    // eject on ch1 while injecting on ch1 in the same cycle
    drive_cycle(put('0, 1, mk(ADDR, 1'b1)), put('0, 1, mk(4'h3, 1'b1)), '0);
    idle_cycles(1, '0);
    idle_cycles(3, '1);

    // fill FIFO with rdy low; the third hit deflects
    for (int i = 0; i < 3; i++) drive_cycle(put('0, 0, mk(ADDR, 1'b1) | FLIT_W'(i << 8)), '0, '0);
    idle_cycles(4, '1);
    // same, but a pop on the third cycle frees a slot
    drive_cycle(put('0, 0, mk(ADDR, 1'b1) | FLIT_W'(16'h1100)), '0, '0);
    drive_cycle(put('0, 0, mk(ADDR, 1'b1) | FLIT_W'(16'h2200)), '0, '0);
    drive_cycle(put('0, 0, mk(ADDR, 1'b1) | FLIT_W'(16'h3300)), '0, 2'b01);
    idle_cycles(4, '1);

    // starvation: busy non-hit ring traffic on ch0 while local flit waits
    for (int i = 0; i < 12; i++)
      drive_cycle(put('0, 0, mk(4'h1, 1'b1) | FLIT_W'(i << 8)), put('0, 0, mk(4'h5, 1'b1)), '0);
    drive_cycle('0, put('0, 0, mk(4'h5, 1'b1)), '0);
    idle_cycles(2, '0);

    random_cycles(1500);

    // saturate the deflection counter: both channels deflect every cycle
    pin = '0;
    for (int c = 0; c < N_CH; c++) pin = put(pin, c, mk(ADDR, 1'b1));
    for (int i = 0; i < 32772; i++) drive_cycle(pin, '0, '0);
    idle_cycles(2, '0);

    reset_mid_traffic();
    lin = '0;
    for (int c = 0; c < N_CH; c++) lin = put(lin, c, mk(4'h6, 1'b1));
    drive_cycle('0, lin, '0);
    idle_cycles(1, '1);
    random_cycles(300);
    idle_cycles(3, '1);

    @(posedge clk);
    #3;
    mon_en = 0;
    chk("out_q_drained", NW'(out_q.size()), '0);
    for (int c = 0; c < N_CH; c++)
      chk($sformatf("eject_drained_ch%0d", c), NW'(ej_q[c].size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
